// File: rtl/energy_conv_pkg.sv
// rtl/energy_conv_pkg.sv - shared helpers for the energy converter blocks
package energy_conv_pkg;

  // Channel index width for a given channel count (callers guarantee nch >= 2).
  function automatic int ch_w(input int nch);
    return $clog2(nch);
  endfunction

  // Largest value representable on data_w unsigned bits.
  function automatic int sat_max(input int data_w);
    return (1 << data_w) - 1;
  endfunction

endpackage

// File: rtl/energy_scale_avg_if.sv
// rtl/energy_scale_avg_if.sv - sample-in / average-out handshake bundle
interface energy_scale_avg_if #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 4,
  parameter int CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic [GAIN_W-1:0] gain;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic [7:0]        drop_cnt;

  modport master (
    output in_valid, in_ch, in_data, gain, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_sat, drop_cnt
  );

  modport slave (
    input  in_valid, in_ch, in_data, gain, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_sat, drop_cnt
  );
endinterface

// File: rtl/energy_sat_mul.sv
// rtl/energy_sat_mul.sv - unsigned sample x gain multiply with saturation to DATA_W
module energy_sat_mul
  import energy_conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 4
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] s,
  output logic              sat
);
  localparam int PW = DATA_W + GAIN_W;
  localparam logic [PW-1:0] SAT_P = PW'(sat_max(DATA_W));

  logic [PW-1:0] prod;

  // Full-width product, clamped to the largest DATA_W value.
  always_comb begin
    prod = PW'(in_data) * PW'(gain);
    sat  = prod > SAT_P;
    s    = sat ? SAT_P[DATA_W-1:0] : prod[DATA_W-1:0];
  end
endmodule

// File: rtl/energy_scale_avg.sv
// rtl/energy_scale_avg.sv - per-channel gain scaling and window averaging; ENERGY_AVG_ROUND_EN selects round-half-up
module energy_scale_avg
  import energy_conv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAIN_W   = 4,
  parameter int NCH      = 4,
  parameter int AVG_LOG2 = 2
) (
  input logic               clk,
  input logic               rst_n,
  energy_scale_avg_if.slave bus
);
  localparam int CH_W = ch_w(NCH);
`ifdef ENERGY_AVG_ROUND_EN
  // One spare bit so the rounding add cannot wrap.
  localparam int ACC_W = DATA_W + AVG_LOG2 + 1;
`else
  localparam int ACC_W = DATA_W + AVG_LOG2;
`endif
  localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NCH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] s;
    logic              sat;
  } stage1_t;

  logic              stall;
  logic              accept;
  logic              ch_ok;
  logic              advance;
  logic              close;
  logic [DATA_W-1:0] mul_s;
  logic              mul_sat;
  stage1_t           s1_q;
  logic              s1_valid;
  logic [7:0]        drop_q;
  logic [ACC_W-1:0]  acc_q  [NCH];
  logic [AVG_LOG2-1:0] cnt_q [NCH];
  logic              satf_q [NCH];
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sat_q;

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign accept        = bus.in_valid && !stall;
  assign ch_ok         = {1'b0, bus.in_ch} < NCH_V;
  assign advance       = s1_valid && !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.drop_cnt  = drop_q;

  energy_sat_mul #(
    .DATA_W(DATA_W),
    .GAIN_W(GAIN_W)
  ) u_sat_mul (
    .in_data(bus.in_data),
    .gain   (bus.gain),
    .s      (mul_s),
    .sat    (mul_sat)
  );

  // Window sum including the stage-1 sample, and its average.
`ifdef ENERGY_AVG_ROUND_EN
  logic [ACC_W-1:0]  rnd;
  logic [DATA_W:0]   quo;
  always_comb begin
    close = cnt_q[s1_q.ch] == '1;
    sum   = acc_q[s1_q.ch] + ACC_W'(s1_q.s);
    rnd   = sum + ACC_W'(1 << (AVG_LOG2 - 1));
    quo   = rnd[ACC_W-1:AVG_LOG2];
    avg   = quo[DATA_W] ? '1 : quo[DATA_W-1:0];
  end
`else
  always_comb begin
    close = cnt_q[s1_q.ch] == '1;
    sum   = acc_q[s1_q.ch] + ACC_W'(s1_q.s);
    avg   = sum[AVG_LOG2 +: DATA_W];
  end
`endif

  // Stage 1: capture the scaled beat; out-of-range channels only bump the drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      drop_q   <= '0;
    end else if (!stall) begin
      s1_valid <= accept && ch_ok;
      s1_q     <= '{ch: bus.in_ch, s: mul_s, sat: mul_sat};
      if (accept && !ch_ok && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Stage 2: per-channel accumulate, clearing the channel when its window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        satf_q[i] <= 1'b0;
      end
    end else if (advance) begin
      if (close) begin
        acc_q[s1_q.ch]  <= '0;
        cnt_q[s1_q.ch]  <= '0;
        satf_q[s1_q.ch] <= 1'b0;
      end else begin
        acc_q[s1_q.ch]  <= sum;
        cnt_q[s1_q.ch]  <= cnt_q[s1_q.ch] + AVG_LOG2'(1);
        satf_q[s1_q.ch] <= satf_q[s1_q.ch] | s1_q.sat;
      end
    end
  end

  // Output register: load on window close, otherwise drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance && close) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= s1_q.ch;
      out_data_q  <= avg;
      out_sat_q   <= satf_q[s1_q.ch] | s1_q.sat;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_energy_scale_avg.sv
// tb/tb_energy_scale_avg.sv - scoreboard bench for energy_scale_avg (NCH=4 and NCH=3 builds)
module tb_energy_scale_avg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  energy_scale_avg_if #(.DATA_W(8), .GAIN_W(4), .CH_W(2)) bus ();
  energy_scale_avg_if #(.DATA_W(8), .GAIN_W(4), .CH_W(2)) bus3 ();

  energy_scale_avg #(.DATA_W(8), .GAIN_W(4), .NCH(4), .AVG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  energy_scale_avg #(.DATA_W(8), .GAIN_W(4), .NCH(3), .AVG_LOG2(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  typedef struct {
    int ch;
    int data;
    bit sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   m_sum [4];
  int   m_cnt [4];
  bit   m_sat [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
      m_sat[c] = 1'b0;
    end
  endtask

  task automatic model_beat(input int ch, input int d, input int g);
    int   p;
    int   s;
    exp_t e;
    p = d * g;
    s = (p > 255) ? 255 : p;
    m_sum[ch] += s;
    m_cnt[ch] += 1;
    m_sat[ch] |= (p > 255);
    if (m_cnt[ch] == 4) begin
      e.ch = ch;
`ifdef ENERGY_AVG_ROUND_EN
      e.data = (m_sum[ch] + 2) / 4;
      if (e.data > 255) e.data = 255;
`else
      e.data = m_sum[ch] / 4;
`endif
      e.sat = m_sat[ch];
      sb.push_back(e);
      m_sum[ch] = 0;
      m_cnt[ch] = 0;
      m_sat[ch] = 1'b0;
    end
  endtask

  task automatic send(input int ch, input int d, input int g);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_data  = 8'(d);
    bus.gain     = 4'(g);
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    check("send_accept", 32'(done), 1);
    if (done) model_beat(ch, d, g);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 0);
  endtask

  // Scoreboard: compare every transferred result against the model queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_sat", 32'(bus.out_sat), 32'(mon_e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0; bus.gain = '0; bus.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_ch = '0; bus3.in_data = '0; bus3.gain = '0; bus3.out_ready = 1'b1;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_ch", 32'(bus.out_ch), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_sat", 32'(bus.out_sat), 0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic window with latency probe: 20+40+60+80 -> 50
    send(0, 10, 2); send(0, 20, 2); send(0, 30, 2); send(0, 40, 2);
    check("lat_accept_edge", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_next_edge", 32'(bus.out_valid), 1);
    wait_drain();

    // Saturation: 255+20+20+20
    send(1, 200, 2); send(1, 10, 2); send(1, 10, 2); send(1, 10, 2);
    wait_drain();

    // Zero gain: no saturation, zero result
    for (int i = 0; i < 4; i++) send(3, 200, 0);
    wait_drain();

    // Interleave ch2 / ch3
    for (int i = 0; i < 4; i++) begin
      send(2, 8, 1);
      send(3, 16, 1);
    end
    wait_drain();

    // Rounding boundary: sum 6
    send(0, 1, 1); send(0, 1, 1); send(0, 2, 1); send(0, 2, 1);
    wait_drain();

    // Backpressure: result pending while more beats arrive
    bus.out_ready = 1'b0;
    send(0, 1, 1); send(0, 2, 1); send(0, 3, 1); send(0, 4, 1);
    fork
      begin
        send(1, 5, 1); send(1, 5, 1); send(1, 5, 1); send(1, 5, 1); send(1, 9, 1);
      end
      begin
        for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
        check("bp_pending", 32'(bus.out_valid), 1);
        repeat (6) begin
          @(negedge clk);
          check("bp_in_ready", 32'(bus.in_ready), 0);
          check("bp_hold_valid", 32'(bus.out_valid), 1);
          check("bp_hold_data", 32'(bus.out_data), (sb.size() > 0) ? 32'(sb[0].data) : 32'hFFFF_FFFF);
          check("bp_hold_ch", 32'(bus.out_ch), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    send(1, 9, 1); send(1, 9, 1); send(1, 9, 1);
    wait_drain();

    // Reset mid-window discards the partial sum
    send(0, 100, 1); send(0, 100, 1);
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_out_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(0, 4, 1);
    wait_drain();
    check("main_drop_cnt", 32'(bus.drop_cnt), 0);

    // NCH=3 build: channel 3 is invalid
    bus3.in_valid = 1'b1; bus3.in_ch = 2'd3; bus3.in_data = 8'd50; bus3.gain = 4'd1;
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("nch3_no_out", 32'(bus3.out_valid), 0);
    end
    check("nch3_drop1", 32'(bus3.drop_cnt), 1);
    bus3.in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    @(negedge clk);
    check("nch3_drop_sat", 32'(bus3.drop_cnt), 255);
    check("nch3_drop_no_out", 32'(bus3.out_valid), 0);

    // NCH=3 build: valid channel 2 still averages (7 x4 -> 7), drop count unchanged
    bus3.in_valid = 1'b1; bus3.in_ch = 2'd2; bus3.in_data = 8'd7; bus3.gain = 4'd1;
    repeat (4) @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    check("nch3_lat_early", 32'(bus3.out_valid), 0);
    @(posedge clk);
    #1;
    check("nch3_out_valid", 32'(bus3.out_valid), 1);
    check("nch3_out_ch", 32'(bus3.out_ch), 2);
    check("nch3_out_data", 32'(bus3.out_data), 7);
    check("nch3_out_sat", 32'(bus3.out_sat), 0);
    check("nch3_drop_hold", 32'(bus3.drop_cnt), 255);

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
